psw_flag_gen: RTL and testbench



---
 rtl/psw_flag_gen.sv | 131 +++++++++++++
 tb/tb_psw_flag_gen.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/psw_flag_gen.sv
// Condition-code generator for the PSW set/reset stage.
// It drives one-cycle J/K pulses into the PSW JK bank, then reads the flags back to verify them.
module psw_flag_gen (
    input  logic        i_clk,
    input  logic        i_clr_n,
    input  logic        i_alu_valid,
    output logic        o_alu_ready,
    input  logic [15:0] i_alu_result,
    input  logic        i_alu_carry,
    input  logic        i_alu_ovf,
    input  logic [1:0]  i_op_class,
    input  logic [3:0]  i_flag_we,
    input  logic        i_cc_req,
    output logic        o_cc_ready,
    input  logic [3:0]  i_cc_set,
    input  logic [3:0]  i_cc_clr,
    input  logic [15:0] i_psw_q,
    output logic [15:0] o_j,
    output logic [15:0] o_k,
    output logic        o_busy,
    output logic        o_mismatch_err
);

    typedef enum logic [1:0] {StIdle, StApply, StCheck} state_e;

    state_e     r_state, w_state_nxt;
    logic [3:0] r_d, w_d_nxt;
    logic [3:0] r_m, w_m_nxt;
    logic [3:0] r_j, w_j_nxt;
    logic [3:0] r_k, w_k_nxt;
    logic       r_err, w_err_nxt;

    logic       w_z, w_n;
    logic [3:0] w_alu_d, w_alu_m;
    logic       w_unused;

    // Bits 15:4 of the PSW belong to other stages.
    assign w_unused = ^i_psw_q[15:4];

    assign w_z = (i_alu_result == 16'h0000);
    assign w_n = i_alu_result[15];

    // Flag order in both vectors: {N, Z, V, C}.
    always_comb begin
        w_alu_d = 4'b0000;
        w_alu_m = 4'b0000;
        unique case (i_op_class)
            2'b01: begin
                w_alu_d = {w_n, w_z, i_alu_ovf, i_alu_carry};
                w_alu_m = i_flag_we;
            end
            2'b10: begin
                w_alu_d = {w_n, w_z, 1'b0, 1'b0};
                w_alu_m = i_flag_we & 4'b1110;
            end
            2'b11: begin
                w_alu_d = {w_n, w_z, w_n ^ i_alu_carry, i_alu_carry};
                w_alu_m = i_flag_we;
            end
            default: begin
                w_alu_d = 4'b0000;
                w_alu_m = 4'b0000;
            end
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_d_nxt     = r_d;
        w_m_nxt     = r_m;
        w_j_nxt     = 4'b0000;
        w_k_nxt     = 4'b0000;
        w_err_nxt   = r_err;
        unique case (r_state)
            StIdle: begin
                if (i_alu_valid) begin
                    w_d_nxt     = w_alu_d;
                    w_m_nxt     = w_alu_m;
                    w_j_nxt     = w_alu_d & w_alu_m;
                    w_k_nxt     = ~w_alu_d & w_alu_m;
                    w_state_nxt = StApply;
                end else if (i_cc_req) begin
                    // Set wins over clear when a flag appears in both.
                    w_d_nxt     = i_cc_set;
                    w_m_nxt     = i_cc_set | i_cc_clr;
                    w_j_nxt     = i_cc_set;
                    w_k_nxt     = i_cc_clr & ~i_cc_set;
                    w_state_nxt = StApply;
                end
            end
            StApply: begin
                w_state_nxt = StCheck;
            end
            StCheck: begin
                if (|((i_psw_q[3:0] ^ r_d) & r_m)) begin
                    w_err_nxt = 1'b1;
                end
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_clr_n) begin
            r_state <= StIdle;
            r_d     <= 4'b0000;
            r_m     <= 4'b0000;
            r_j     <= 4'b0000;
            r_k     <= 4'b0000;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_d     <= w_d_nxt;
            r_m     <= w_m_nxt;
            r_j     <= w_j_nxt;
            r_k     <= w_k_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign o_alu_ready    = (r_state == StIdle);
    assign o_cc_ready     = o_alu_ready & ~i_alu_valid;
    assign o_busy         = (r_state != StIdle);
    assign o_j            = {12'h000, r_j};
    assign o_k            = {12'h000, r_k};
    assign o_mismatch_err = r_err;

endmodule

// File: tb/tb_psw_flag_gen.sv
// Bench for psw_flag_gen: behavioural PSW JK bank, expected J/K scoreboard,
// and one task per scenario.
module tb_psw_flag_gen;

    logic        clk;
    logic        clr_n;
    logic        alu_valid;
    logic        alu_ready;
    logic [15:0] alu_result;
    logic        alu_carry;
    logic        alu_ovf;
    logic [1:0]  op_class;
    logic [3:0]  flag_we;
    logic        cc_req;
    logic        cc_ready;
    logic [3:0]  cc_set;
    logic [3:0]  cc_clr;
    logic [15:0] psw_q;
    logic [15:0] j_vec;
    logic [15:0] k_vec;
    logic        busy;
    logic        mismatch_err;

    logic [15:0] psw;
    logic        psw_load;
    logic [15:0] psw_init;
    logic        fault_z;

    logic [31:0] exp_q[$];
    logic [31:0] exp;
    int          n_pass;
    int          n_total;

    psw_flag_gen dut (
        .i_clk          (clk),
        .i_clr_n        (clr_n),
        .i_alu_valid    (alu_valid),
        .o_alu_ready    (alu_ready),
        .i_alu_result   (alu_result),
        .i_alu_carry    (alu_carry),
        .i_alu_ovf      (alu_ovf),
        .i_op_class     (op_class),
        .i_flag_we      (flag_we),
        .i_cc_req       (cc_req),
        .o_cc_ready     (cc_ready),
        .i_cc_set       (cc_set),
        .i_cc_clr       (cc_clr),
        .i_psw_q        (psw_q),
        .o_j            (j_vec),
        .o_k            (k_vec),
        .o_busy         (busy),
        .o_mismatch_err (mismatch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External PSW JK bank; fault_z forces the Z readback to 0.
    always @(posedge clk) begin
        if (psw_load) psw <= psw_init;
        else          psw <= (j_vec & ~psw) | (~k_vec & psw);
    end
    assign psw_q = fault_z ? (psw & ~16'h0004) : psw;

    task automatic send_alu(input logic [15:0] res, input logic c, input logic o,
                            input logic [1:0] cls, input logic [3:0] we, input logic [31:0] e);
        alu_result = res; alu_carry = c; alu_ovf = o; op_class = cls; flag_we = we;
        alu_valid  = 1'b1;
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        alu_valid = 1'b0;
    endtask

    task automatic send_cc(input logic [3:0] s, input logic [3:0] c, input logic [31:0] e);
        cc_set = s; cc_clr = c; cc_req = 1'b1;
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        cc_req = 1'b0;
    endtask

    task automatic test_reset();
        clr_n = 1'b0; psw_load = 1'b1; psw_init = 16'hA5F0;
        repeat (2) @(negedge clk);
        n_total++; if (j_vec !== 16'h0) $display("FAIL rst_j: got %h want 0000", j_vec); else n_pass++;
        n_total++; if (k_vec !== 16'h0) $display("FAIL rst_k: got %h want 0000", k_vec); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (mismatch_err !== 1'b0) $display("FAIL rst_err: got %b want 0", mismatch_err); else n_pass++;
        clr_n = 1'b1; psw_load = 1'b0;
        @(negedge clk);
        n_total++; if (alu_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", alu_ready); else n_pass++;
        n_total++; if (cc_ready !== 1'b1) $display("FAIL rst_cc_ready: got %b want 1", cc_ready); else n_pass++;
    endtask

    task automatic test_arith();
        send_alu(16'h0000, 1'b1, 1'b0, 2'b01, 4'hF, {16'h0005, 16'h000A});
        exp = exp_q.pop_front();
        n_total++; if (j_vec !== exp[31:16]) $display("FAIL arith_j: got %h want %h", j_vec, exp[31:16]); else n_pass++;
        n_total++; if (k_vec !== exp[15:0]) $display("FAIL arith_k: got %h want %h", k_vec, exp[15:0]); else n_pass++;
        n_total++; if (busy !== 1'b1 || alu_ready !== 1'b0)
            $display("FAIL arith_busy: got busy=%b ready=%b want 1/0", busy, alu_ready); else n_pass++;
        @(negedge clk);
        n_total++; if (j_vec !== 16'h0 || k_vec !== 16'h0)
            $display("FAIL arith_jk_check: got %h/%h want 0000/0000", j_vec, k_vec); else n_pass++;
        n_total++; if (psw_q !== 16'hA5F5) $display("FAIL arith_psw: got %h want a5f5", psw_q); else n_pass++;
        @(negedge clk);
        n_total++; if (alu_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL arith_ready: got ready=%b busy=%b want 1/0", alu_ready, busy); else n_pass++;
        n_total++; if (mismatch_err !== 1'b0) $display("FAIL arith_err: got %b want 0", mismatch_err); else n_pass++;
    endtask

    task automatic test_logic();
        send_alu(16'h8001, 1'b0, 1'b1, 2'b10, 4'hF, {16'h0008, 16'h0006});
        exp = exp_q.pop_front();
        n_total++; if (j_vec !== exp[31:16]) $display("FAIL logic_j: got %h want %h", j_vec, exp[31:16]); else n_pass++;
        n_total++; if (k_vec !== exp[15:0]) $display("FAIL logic_k: got %h want %h", k_vec, exp[15:0]); else n_pass++;
        @(negedge clk);
        n_total++; if (psw_q[3:0] !== 4'b1001) $display("FAIL logic_psw: got %b want 1001", psw_q[3:0]); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_shift();
        send_alu(16'h8000, 1'b0, 1'b0, 2'b11, 4'hF, {16'h000A, 16'h0005});
        exp = exp_q.pop_front();
        n_total++; if (j_vec !== exp[31:16]) $display("FAIL shift_j: got %h want %h", j_vec, exp[31:16]); else n_pass++;
        n_total++; if (k_vec !== exp[15:0]) $display("FAIL shift_k: got %h want %h", k_vec, exp[15:0]); else n_pass++;
        // Request raised while busy must be ignored.
        alu_result = 16'h0000; alu_valid = 1'b1;
        @(negedge clk);
        n_total++; if (psw_q[3:0] !== 4'b1010) $display("FAIL shift_psw: got %b want 1010", psw_q[3:0]); else n_pass++;
        n_total++; if (j_vec !== 16'h0) $display("FAIL shift_busy_ignored: got %h want 0000", j_vec); else n_pass++;
        alu_valid = 1'b0;
        @(negedge clk);
        n_total++; if (alu_ready !== 1'b1) $display("FAIL shift_ready: got %b want 1", alu_ready); else n_pass++;
    endtask

    task automatic test_none();
        send_alu(16'h0000, 1'b1, 1'b1, 2'b00, 4'hF, 32'h0);
        exp = exp_q.pop_front();
        n_total++; if ({j_vec, k_vec} !== exp) $display("FAIL none_jk: got %h want %h", {j_vec, k_vec}, exp); else n_pass++;
        n_total++; if (busy !== 1'b1) $display("FAIL none_busy: got %b want 1", busy); else n_pass++;
        @(negedge clk);
        n_total++; if (psw_q[3:0] !== 4'b1010) $display("FAIL none_psw: got %b want 1010", psw_q[3:0]); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        alu_result = 16'h0001; alu_carry = 1'b0; alu_ovf = 1'b0; op_class = 2'b01; flag_we = 4'hF;
        alu_valid = 1'b1; cc_set = 4'h1; cc_clr = 4'h0; cc_req = 1'b1;
        exp_q.push_back({16'h0000, 16'h000F});
        exp_q.push_back({16'h0001, 16'h0000});
        #1;
        n_total++; if (cc_ready !== 1'b0) $display("FAIL both_cc_ready: got %b want 0", cc_ready); else n_pass++;
        @(posedge clk);
        @(negedge clk);
        alu_valid = 1'b0;
        exp = exp_q.pop_front();
        n_total++; if ({j_vec, k_vec} !== exp) $display("FAIL both_alu_jk: got %h want %h", {j_vec, k_vec}, exp); else n_pass++;
        repeat (2) @(negedge clk);
        n_total++; if (cc_ready !== 1'b1) $display("FAIL both_cc_ready2: got %b want 1", cc_ready); else n_pass++;
        @(posedge clk);
        @(negedge clk);
        cc_req = 1'b0;
        exp = exp_q.pop_front();
        n_total++; if ({j_vec, k_vec} !== exp) $display("FAIL both_cc_jk: got %h want %h", {j_vec, k_vec}, exp); else n_pass++;
        repeat (2) @(negedge clk);
        send_cc(4'h2, 4'h2, {16'h0002, 16'h0000});
        exp = exp_q.pop_front();
        n_total++; if ({j_vec, k_vec} !== exp) $display("FAIL setclr_jk: got %h want %h", {j_vec, k_vec}, exp); else n_pass++;
        repeat (2) @(negedge clk);
        n_total++; if (psw_q[3:0] !== 4'b0011) $display("FAIL both_psw: got %b want 0011", psw_q[3:0]); else n_pass++;
        n_total++; if (mismatch_err !== 1'b0) $display("FAIL both_err: got %b want 0", mismatch_err); else n_pass++;
    endtask

    task automatic test_cc_random();
        logic [3:0] s, c, flags;
        flags = psw_q[3:0];
        for (int i = 0; i < 8; i++) begin
            s = 4'($urandom);
            c = 4'($urandom);
            // A flag listed in both set and clear ends up set.
            send_cc(s, c, {12'h000, s, 12'h000, c & ~s});
            flags = (flags | s) & ~(c & ~s);
            exp = exp_q.pop_front();
            n_total++; if ({j_vec, k_vec} !== exp)
                $display("FAIL cc_rand_jk[%0d]: got %h want %h", i, {j_vec, k_vec}, exp); else n_pass++;
            @(negedge clk);
            n_total++; if (psw_q[3:0] !== flags)
                $display("FAIL cc_rand_psw[%0d]: got %b want %b", i, psw_q[3:0], flags); else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_fault();
        fault_z = 1'b1;
        send_alu(16'h0000, 1'b0, 1'b0, 2'b01, 4'hF, {16'h0004, 16'h000B});
        exp = exp_q.pop_front();
        n_total++; if ({j_vec, k_vec} !== exp) $display("FAIL fault_jk: got %h want %h", {j_vec, k_vec}, exp); else n_pass++;
        repeat (2) @(negedge clk);
        n_total++; if (mismatch_err !== 1'b1) $display("FAIL fault_err: got %b want 1", mismatch_err); else n_pass++;
        fault_z = 1'b0;
        send_alu(16'h8000, 1'b0, 1'b0, 2'b11, 4'hF, {16'h000A, 16'h0005});
        exp = exp_q.pop_front();
        n_total++; if ({j_vec, k_vec} !== exp) $display("FAIL fault_clean_jk: got %h want %h", {j_vec, k_vec}, exp); else n_pass++;
        repeat (2) @(negedge clk);
        n_total++; if (mismatch_err !== 1'b1) $display("FAIL fault_sticky: got %b want 1", mismatch_err); else n_pass++;
        clr_n = 1'b0;
        @(negedge clk);
        clr_n = 1'b1;
        n_total++; if (mismatch_err !== 1'b0) $display("FAIL fault_clear: got %b want 0", mismatch_err); else n_pass++;
    endtask

    task automatic test_reset_apply();
        send_alu(16'h8000, 1'b0, 1'b0, 2'b01, 4'hF, {16'h0008, 16'h0007});
        exp = exp_q.pop_front();
        n_total++; if ({j_vec, k_vec} !== exp) $display("FAIL rapply_jk: got %h want %h", {j_vec, k_vec}, exp); else n_pass++;
        clr_n = 1'b0;
        @(negedge clk);
        n_total++; if (j_vec !== 16'h0 || k_vec !== 16'h0)
            $display("FAIL rapply_jk0: got %h/%h want 0000/0000", j_vec, k_vec); else n_pass++;
        n_total++; if (busy !== 1'b0 || mismatch_err !== 1'b0)
            $display("FAIL rapply_state: got busy=%b err=%b want 0/0", busy, mismatch_err); else n_pass++;
        clr_n = 1'b1;
        @(negedge clk);
        n_total++; if (alu_ready !== 1'b1 || j_vec !== 16'h0)
            $display("FAIL rapply_ready: got ready=%b j=%h want 1/0000", alu_ready, j_vec); else n_pass++;
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        clr_n = 1'b0; alu_valid = 1'b0; alu_result = 16'h0; alu_carry = 1'b0; alu_ovf = 1'b0;
        op_class = 2'b00; flag_we = 4'h0; cc_req = 1'b0; cc_set = 4'h0; cc_clr = 4'h0;
        psw_load = 1'b1; psw_init = 16'hA5F0; fault_z = 1'b0;
        @(negedge clk);
        test_reset();
        test_arith();
        test_logic();
        test_shift();
        test_none();
        test_back_to_back();
        test_cc_random();
        test_fault();
        test_reset_apply();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
